// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared BCD constants and the 7-segment decode table/function.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Active-high segments {g,f,e,d,c,b,a} for digits 0..9
    localparam logic [6:0] SEG7_LUT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    function automatic logic [6:0] seg7_decode(input logic [3:0] d);
        seg7_decode = (d <= BCD_MAX) ? SEG7_LUT[d] : 7'h00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_multidigit_counter_digit.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit
// Brief    : One BCD decade with ripple carry/borrow and clamped parallel load.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             cin,
    input  logic             freeze,
    input  logic             up_dn,
    input  logic             load,
    input  logic [BCD_W-1:0] ld_val,
    output logic [BCD_W-1:0] q,
    output logic             cout
);

    logic [BCD_W-1:0] r_q;
    logic             w_at_lim;
    logic [BCD_W-1:0] w_ld;

    assign w_at_lim = up_dn ? (r_q == BCD_MAX) : (r_q == '0);
    assign w_ld     = (ld_val > BCD_MAX) ? BCD_MAX : ld_val;
    assign cout     = w_at_lim & cin;
    assign q        = r_q;

    // freeze suppresses the step when the whole counter saturates at a limit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= w_ld;
        end else if (cin && !freeze) begin
            if (up_dn)
                r_q <= w_at_lim ? '0 : r_q + 1'b1;
            else
                r_q <= w_at_lim ? BCD_MAX : r_q - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_multidigit_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_multidigit_counter
// Brief    : N-digit BCD up/down counter, prescaled tick, load, wrap/saturate,
//            multiplexed 7-segment scan output.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_multidigit_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1000,
    parameter int SCAN_DIV = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  sat_mode,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  load_err,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     dig_sel
);

    localparam int c_pre_w  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int c_scan_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_idx_w  = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;

    logic [c_pre_w-1:0]   r_pre;
    logic [c_scan_w-1:0]  r_scan_cnt;
    logic [c_idx_w-1:0]   r_scan_idx;
    logic                 r_tc;
    logic                 r_load_err;
    logic [6:0]           r_seg;
    logic [DIGITS-1:0]    r_dig_sel;

    logic                 w_tick;
    logic                 w_hit;
    logic                 w_freeze;
    logic                 w_over;
    logic [DIGITS:0]      w_carry;
    logic [4*DIGITS-1:0]  w_count;
    logic [BCD_W-1:0]     w_sel_digit;

    assign w_tick     = en & (r_pre == c_pre_w'(PRESCALE - 1));
    assign w_carry[0] = w_tick;
    // Carry out of the top decade means every digit sits at the limit on a tick
    assign w_hit      = w_carry[DIGITS];
    assign w_freeze   = sat_mode & w_hit;

    always_ff @(posedge clk) begin
        if (rst)
            r_pre <= '0;
        else if (load)
            r_pre <= '0;
        else if (en)
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
    end

    generate
        for (genvar i = 0; i < DIGITS; i++) begin : g_digits
            bcd_digit u_digit (
                .clk    (clk),
                .rst    (rst),
                .cin    (w_carry[i]),
                .freeze (w_freeze),
                .up_dn  (up_dn),
                .load   (load),
                .ld_val (load_val[4*i +: 4]),
                .q      (w_count[4*i +: 4]),
                .cout   (w_carry[i+1])
            );
        end
    endgenerate

    always_comb begin
        w_over = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > BCD_MAX)
                w_over = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tc       <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_tc       <= w_hit & ~load;
            r_load_err <= load & w_over;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_scan_idx <= '0;
        end else if (r_scan_cnt == c_scan_w'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_scan_idx <= (r_scan_idx == c_idx_w'(DIGITS - 1)) ? '0 : r_scan_idx + 1'b1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    assign w_sel_digit = w_count[{r_scan_idx, 2'b00} +: BCD_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg     <= seg7_decode(4'd0);
            r_dig_sel <= DIGITS'(1);
        end else begin
            r_seg     <= seg7_decode(w_sel_digit);
            r_dig_sel <= DIGITS'(1) << r_scan_idx;
        end
    end

    assign count    = w_count;
    assign tc       = r_tc;
    assign load_err = r_load_err;
    assign seg      = r_seg;
    assign dig_sel  = r_dig_sel;

endmodule
`default_nettype wire

// File: tb/tb_bcd_multidigit_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_multidigit_counter
// Brief    : Randomized bench against a decimal-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_multidigit_counter;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 2;
    localparam int SCAN_DIV = 4;
    localparam int MAXV     = 9999;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        up_dn = 1'b1;
    logic        sat_mode = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] count;
    logic        tc;
    logic        load_err;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;

    int n_total = 0;
    int n_bad   = 0;

    // reference state (decimal integers), reset values
    int         m_val = 0;
    int         m_pre = 0;
    int         m_scan_cnt = 0;
    int         m_scan_idx = 0;
    bit         m_tc = 0;
    bit         m_lerr = 0;
    logic [6:0] m_seg = 7'h3F;
    logic [3:0] m_dig = 4'b0001;

    logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    bcd_multidigit_counter #(
        .DIGITS   (DIGITS),
        .PRESCALE (PRESCALE),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .sat_mode (sat_mode),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .load_err (load_err),
        .seg      (seg),
        .dig_sel  (dig_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r = '0;
        int t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Advance the model by one clock edge given the inputs applied for it
    task automatic model_step(input bit r, input bit e, input bit u, input bit s,
                              input bit l, input logic [15:0] lv);
        int  digit, mult, n;
        bit  tick, err;
        if (r) begin
            m_val = 0; m_pre = 0; m_scan_cnt = 0; m_scan_idx = 0;
            m_tc = 0; m_lerr = 0; m_seg = 7'h3F; m_dig = 4'b0001;
            return;
        end
        digit = m_val;
        for (int k = 0; k < m_scan_idx; k++) digit = digit / 10;
        m_seg = seg_tab[digit % 10];
        m_dig = 4'(1 << m_scan_idx);
        if (m_scan_cnt == SCAN_DIV - 1) begin
            m_scan_cnt = 0;
            m_scan_idx = (m_scan_idx + 1) % DIGITS;
        end else begin
            m_scan_cnt++;
        end
        tick = e && (m_pre == PRESCALE - 1);
        if (l) begin
            m_val = 0; mult = 1; err = 0;
            for (int i = 0; i < DIGITS; i++) begin
                n = int'(lv[4*i +: 4]);
                if (n > 9) begin n = 9; err = 1; end
                m_val += n * mult;
                mult *= 10;
            end
            m_lerr = err; m_pre = 0; m_tc = 0;
        end else begin
            m_lerr = 0;
            m_tc = 0;
            if (e) m_pre = tick ? 0 : m_pre + 1;
            if (tick) begin
                if (u) begin
                    if (m_val == MAXV) begin m_tc = 1; m_val = s ? MAXV : 0; end
                    else m_val++;
                end else begin
                    if (m_val == 0) begin m_tc = 1; m_val = s ? 0 : MAXV; end
                    else m_val--;
                end
            end
        end
    endtask

    // Check current outputs, then apply inputs for the next edge
    task automatic cycle(input bit r, input bit e, input bit u, input bit s,
                         input bit l, input logic [15:0] lv);
        @(negedge clk);
        check("count",    32'(count),    32'(to_bcd(m_val)));
        check("tc",       32'(tc),       32'(m_tc));
        check("load_err", 32'(load_err), 32'(m_lerr));
        check("seg",      32'(seg),      32'(m_seg));
        check("dig_sel",  32'(dig_sel),  32'(m_dig));
        rst = r; en = e; up_dn = u; sat_mode = s; load = l; load_val = lv;
        model_step(r, e, u, s, l, lv);
    endtask

    initial begin
        bit          r, e, u, s, l;
        logic [15:0] lv;
        int          guard;
        // reset
        cycle(1, 0, 1, 0, 0, 16'h0000);
        cycle(1, 0, 1, 0, 0, 16'h0000);
        // up carry
        cycle(0, 0, 1, 0, 1, 16'h0199);
        repeat (5) cycle(0, 1, 1, 0, 0, 16'h0000);
        // wrap up then wrap down
        cycle(0, 1, 1, 0, 1, 16'h9999);
        repeat (4) cycle(0, 1, 1, 0, 0, 16'h0000);
        repeat (4) cycle(0, 1, 0, 0, 0, 16'h0000);
        // saturate at zero going down
        cycle(0, 1, 0, 1, 1, 16'h0000);
        repeat (8) cycle(0, 1, 0, 1, 0, 16'h0000);
        // saturate at all-nines going up
        cycle(0, 1, 1, 1, 1, 16'h9999);
        repeat (6) cycle(0, 1, 1, 1, 0, 16'h0000);
        // load clamp coincident with a tick
        guard = 0;
        while (m_pre != PRESCALE - 1 && guard < 8) begin
            cycle(0, 1, 1, 0, 0, 16'h0000);
            guard++;
        end
        cycle(0, 1, 1, 0, 1, 16'h3A7F);
        repeat (4) cycle(0, 1, 1, 0, 0, 16'h0000);
        // scan with counting disabled
        cycle(0, 0, 1, 0, 1, 16'h1234);
        repeat (20) cycle(0, 0, 1, 0, 0, 16'h0000);
        // reset mid-operation
        cycle(1, 1, 1, 0, 0, 16'h0000);
        // randomized traffic
        u = 1; s = 0;
        for (int k = 0; k < 1500; k++) begin
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) u = ~u;
            if ($urandom_range(0, 59) == 0) s = ~s;
            l = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 3))
                0:       lv = 16'(4'($urandom_range(0, 15)) |
                              (4'($urandom_range(0, 15)) << 4) |
                              (12'($urandom_range(0, 15)) << 8) |
                              (16'($urandom_range(0, 15)) << 12));
                1:       lv = 16'h9998;
                2:       lv = 16'h0001;
                default: lv = to_bcd(int'($urandom_range(0, MAXV)));
            endcase
            cycle(r, e, u, s, l, lv);
        end
        cycle(0, 0, 1, 0, 0, 16'h0000);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
